// File: rtl/pc_fetch_queue_pkg.sv
// Shared RISC-V core definitions used by the fetch front end.
// Holds the datapath width, default reset PC and the canonical NOP encoding.
package riscv_defs;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          QDEPTH    = 2;

    // Instruction fetches are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_queue_fetch_queue.sv
// fetch_queue: DEPTH-entry circular FIFO of {pc, instr} pairs with a synchronous clear.
// Handshake: enq is taken when the FIFO is not full or a dequeue happens the same cycle;
// deq is taken only when count is non-zero. clear and rst both empty the FIFO at the edge.
module fetch_queue
    import riscv_defs::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enq,
    input  logic [W-1:0]  enq_pc,
    input  logic [W-1:0]  enq_instr,
    input  logic          deq,
    output logic [W-1:0]  head_pc,
    output logic [W-1:0]  head_instr,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  pc_mem    [DEPTH];
    logic [W-1:0]  instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_enq;
    logic          do_deq;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_deq = deq && (count != '0);
    assign do_enq = enq && ((count != CW'(DEPTH)) || do_deq);

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is pure datapath; stale entries are never visible because the top masks on count.
    always_ff @(posedge clk) begin
        if (do_enq && !(rst || clear)) begin
            pc_mem[wr_ptr]    <= enq_pc;
            instr_mem[wr_ptr] <= enq_instr;
        end
    end

endmodule

// File: rtl/pc_fetch_queue.sv
// Instruction-fetch front end: PC, one-deep read tracking with epoch tag, and a fetch queue.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_TRAP_EN.
module pc_fetch_queue #(
    parameter int          XLEN     = riscv_defs::XLEN,
    parameter logic [31:0] RESET_PC = riscv_defs::RESET_PC,
    parameter int          QDEPTH   = riscv_defs::QDEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic            fetch_misalign
);

    import riscv_defs::*;

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] head_pc;
    logic [XLEN-1:0] head_instr;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            inflight;
    logic            tag;
    logic            epoch;
    logic            halted;
    logic            deq;
    logic            issue;
    logic            rsp_ok;

    assign target = redirect_pc & ~XLEN'(3);

    // Handshake: an instruction leaves the queue when out_valid is high and stall is low;
    // a memory read is only issued when a slot is guaranteed for its return next cycle.
    assign out_valid = (count != '0);
    assign deq       = out_valid && !stall;
    assign occupancy = {1'b0, count} - (CW + 1)'(deq) + (CW + 1)'(inflight);
    assign issue     = !rst && !redirect_valid && !halted && (occupancy < (CW + 1)'(QDEPTH));
    assign rsp_ok    = inflight && (tag == epoch);

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign out_pc    = out_valid ? head_pc : '0;
    assign out_instr = out_valid ? head_instr : XLEN'(NOP_INSTR);

    fetch_queue #(
        .W     (XLEN),
        .DEPTH (QDEPTH),
        .CW    (CW)
    ) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .enq        (rsp_ok),
        .enq_pc     (req_pc),
        .enq_instr  (imem_rdata),
        .deq        (deq),
        .head_pc    (head_pc),
        .head_instr (head_instr),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= XLEN'(RESET_PC);
            req_pc   <= '0;
            inflight <= 1'b0;
            tag      <= 1'b0;
            epoch    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag    <= epoch;
                req_pc <= pc;
                pc     <= pc + XLEN'(4);
            end
            // Toggling the epoch orphans any read that is still on its way back.
            if (redirect_valid) begin
                pc    <= target;
                epoch <= ~epoch;
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign halted = 1'b0;
`endif

    assign fetch_misalign = halted;

endmodule
